// File: rtl/miner_pkg.sv
// Shared constants for the sha256_core arbiter: widths, core mode, FSM
// encodings and a small index helper.
package miner_pkg;

  localparam int BLOCK_W       = 512;
  localparam int DIGEST_W      = 256;
  localparam int DEFAULT_N_REQ = 4;

  localparam logic SHA_MODE_256 = 1'b1;

  // FSM encodings kept as plain constants so older code can compare them directly
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ST_RESP       = 3'd4;

  // Per-job control bits captured at grant time
  typedef struct packed {
    logic first;
    logic last;
  } job_flags_t;

  // Requester index after idx, wrapping from n-1 back to 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sha_core_arbiter_if.sv
// Requester-side bundle: job requests in, accept pulses and responses out.
interface sha_core_arbiter_if #(
  parameter int N_REQ = miner_pkg::DEFAULT_N_REQ
);
  import miner_pkg::*;

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_first;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ*BLOCK_W-1:0] req_block;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         rsp_valid;
  logic                     rsp_error;
  logic [DIGEST_W-1:0]      rsp_digest;

  // Requesters drive jobs and observe accepts/responses
  modport master (
    output req_valid, req_first, req_last, req_block,
    input  req_ready, rsp_valid, rsp_error, rsp_digest
  );

  // The arbiter consumes jobs and returns accepts/responses
  modport slave (
    input  req_valid, req_first, req_last, req_block,
    output req_ready, rsp_valid, rsp_error, rsp_digest
  );

endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin grant with a lock that pins the grant to a single owner while a
// multi-block message is in flight.
module rr_lock_arbiter
  import miner_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             arb_en,      // arbitration allowed this cycle
  input  logic             lock_set,    // pin future grants to lock_id
  input  logic [ID_W-1:0]  lock_id,
  input  logic             advance,     // release lock, move pointer past adv_id
  input  logic [ID_W-1:0]  adv_id,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid,
  output logic             lock_valid,
  output logic [ID_W-1:0]  lock_owner
);

  logic [ID_W-1:0]  ptr_reg;
  logic             lock_valid_reg;
  logic [ID_W-1:0]  lock_owner_reg;
  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] eligible;
  logic [ID_W:0]    cand;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner
      assign owner_mask[gi] = (lock_owner_reg == ID_W'(gi));
    end
  endgenerate

  // While locked only the owner may compete
  assign eligible   = lock_valid_reg ? (req & owner_mask) : req;
  assign lock_valid = lock_valid_reg;
  assign lock_owner = lock_owner_reg;

  // Pick the first eligible requester at or after the pointer
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (arb_en && !grant_valid && eligible[cand[ID_W-1:0]]) begin
        grant_valid               = 1'b1;
        grant_idx                 = cand[ID_W-1:0];
        grant[cand[ID_W-1:0]]     = 1'b1;
      end
    end
  end

  // Pointer and lock bookkeeping; a release always wins over a new lock
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= '0;
      lock_valid_reg <= 1'b0;
      lock_owner_reg <= '0;
    end else if (advance) begin
      lock_valid_reg <= 1'b0;
      ptr_reg        <= ID_W'(wrap_inc(int'(adv_id), N_REQ));
    end else if (lock_set) begin
      lock_valid_reg <= 1'b1;
      lock_owner_reg <= lock_id;
    end
  end

endmodule

// File: rtl/sha_core_arbiter.sv
// Shares one sha256_core among N_REQ requesters: grants a job, pulses
// init/next, waits for the digest and returns it to the issuing requester.
module sha_core_arbiter
  import miner_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  sha_core_arbiter_if.slave    req_if,
  output logic                 core_init,
  output logic                 core_next,
  output logic                 core_mode,
  output logic [BLOCK_W-1:0]   core_block,
  input  logic                 core_ready,
  input  logic [DIGEST_W-1:0]  core_digest,
  input  logic                 core_digest_valid,
  output logic                 busy
);

  logic [2:0]          state_reg, state_next;
  logic [ID_W-1:0]     gnt_id_reg;
  job_flags_t          flags_reg;
  logic                err_reg;
  logic [BLOCK_W-1:0]  core_block_reg;
  logic                core_init_reg, core_next_reg;
  logic [N_REQ-1:0]    rsp_valid_reg;
  logic                rsp_error_reg;
  logic [DIGEST_W-1:0] rsp_digest_reg;

  logic [BLOCK_W-1:0]  req_blk_arr [N_REQ];
  logic [N_REQ-1:0]    gnt_onehot;
  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic                lock_valid;
  logic [ID_W-1:0]     lock_owner;
  logic                arb_en, reject, lock_set, advance, digest_hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_blk_arr[gi] = req_if.req_block[gi*BLOCK_W +: BLOCK_W];
      assign gnt_onehot[gi]  = (gnt_id_reg == ID_W'(gi));
    end
  endgenerate

  // Never grant while reset is held so req_ready stays at its reset value
  assign arb_en     = (state_reg == ST_IDLE) && core_ready && !reset;
  // A continuation is only legal from the requester that holds the lock
  assign reject     = !req_if.req_first[grant_idx] &&
                      !(lock_valid && (lock_owner == grant_idx));
  assign lock_set   = (state_reg == ST_ISSUE) && flags_reg.first && !flags_reg.last;
  assign advance    = (state_reg == ST_RESP) && (flags_reg.last || err_reg);
  // WAIT_START guarantees this is the digest of the job we issued
  assign digest_hit = (state_reg == ST_WAIT_DONE) && core_ready && core_digest_valid;

  rr_lock_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk         (CLOCK_50),
    .reset       (reset),
    .req         (req_if.req_valid),
    .arb_en      (arb_en),
    .lock_set    (lock_set),
    .lock_id     (gnt_id_reg),
    .advance     (advance),
    .adv_id      (gnt_id_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .lock_valid  (lock_valid),
    .lock_owner  (lock_owner)
  );

  assign req_if.req_ready  = grant;
  assign req_if.rsp_valid  = rsp_valid_reg;
  assign req_if.rsp_error  = rsp_error_reg;
  assign req_if.rsp_digest = rsp_digest_reg;
  assign core_init         = core_init_reg;
  assign core_next         = core_next_reg;
  assign core_mode         = SHA_MODE_256;
  assign core_block        = core_block_reg;
  assign busy              = (state_reg != ST_IDLE);

  // Next-state selection for the job sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (grant_valid) state_next = reject ? ST_RESP : ST_ISSUE;
      ST_ISSUE:      state_next = ST_WAIT_START;
      ST_WAIT_START: if (!core_ready) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (digest_hit) state_next = ST_RESP;
      ST_RESP:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Job capture, core pulses and response registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      gnt_id_reg     <= '0;
      flags_reg      <= '0;
      err_reg        <= 1'b0;
      core_block_reg <= '0;
      core_init_reg  <= 1'b0;
      core_next_reg  <= 1'b0;
      rsp_valid_reg  <= '0;
      rsp_error_reg  <= 1'b0;
      rsp_digest_reg <= '0;
    end else begin
      state_reg     <= state_next;
      core_init_reg <= 1'b0;
      core_next_reg <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_error_reg <= 1'b0;
      if (grant_valid) begin
        gnt_id_reg       <= grant_idx;
        flags_reg.first  <= req_if.req_first[grant_idx];
        flags_reg.last   <= req_if.req_last[grant_idx];
        core_block_reg   <= req_blk_arr[grant_idx];
        err_reg          <= reject;
        if (reject) begin
          rsp_valid_reg <= grant;
          rsp_error_reg <= 1'b1;
        end else begin
          core_init_reg <= req_if.req_first[grant_idx];
          core_next_reg <= !req_if.req_first[grant_idx];
        end
      end
      if (digest_hit) begin
        rsp_digest_reg <= core_digest;
        rsp_valid_reg  <= gnt_onehot;
      end
    end
  end

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter with a behavioural sha256_core stand-in.
module tb_sha_core_arbiter;
  import miner_pkg::*;

  localparam int LAT = 10;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  typedef struct {
    int         r;
    bit         err;
    logic [255:0] dig;
  } rsp_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          core_init, core_next, core_mode, busy;
  logic [511:0]  core_block;
  logic          core_ready        = 1'b1;
  logic          core_digest_valid = 1'b0;
  logic [255:0]  core_digest       = '0;

  logic          core_start = 1'b0;
  logic [511:0]  pend_blk   = '0;
  logic          pend_init  = 1'b0;
  int            core_cnt   = 0;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   hs_viol = 0;
  int   next_cnt = 0;
  int   grant_q[$];
  int   grant_cyc_q[$];
  int   init_cyc_q[$];
  rsp_t rsp_q[$];

  sha_core_arbiter_if #(.N_REQ(4)) bus ();

  sha_core_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .req_if            (bus),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_mode         (core_mode),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid),
    .busy              (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Stand-in digest: the real SHA-256 of "abc", otherwise a tagged fold of the block
  function automatic logic [255:0] model_digest(input logic [511:0] blk, input logic is_init);
    if (is_init && blk == ABC_BLK) return ABC_DIG;
    return blk[255:0] ^ {8{is_init ? 32'hA5A5A5A5 : 32'h5A5A5A5A}};
  endfunction

  function automatic logic [511:0] mk_blk(input int tag);
    return {16{(32'(tag) * 32'h01010101) ^ 32'hDEAD0000}};
  endfunction

  // Core model: ready drops one cycle after a pulse, stale digest_valid lingers meanwhile
  always @(posedge CLOCK_50) begin
    if (core_init || core_next) begin
      core_start <= 1'b1;
      pend_blk   <= core_block;
      pend_init  <= core_init;
    end else if (core_start) begin
      core_start        <= 1'b0;
      core_ready        <= 1'b0;
      core_digest_valid <= 1'b0;
      core_cnt          <= LAT;
    end else if (!core_ready) begin
      if (core_cnt == 0) begin
        core_ready        <= 1'b1;
        core_digest_valid <= 1'b1;
        core_digest       <= model_digest(pend_blk, pend_init);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then release accepted requests after the edge
  task automatic tick();
    logic [3:0] taken;
    @(negedge CLOCK_50);
    cyc++;
    taken = bus.req_ready;
    if (taken != 0) begin
      if (!$onehot(taken) || !core_ready) hs_viol++;
      for (int r = 0; r < 4; r++) begin
        if (taken[r]) begin
          grant_q.push_back(r);
          grant_cyc_q.push_back(cyc);
        end
      end
    end
    if (core_init) init_cyc_q.push_back(cyc);
    if (core_next) next_cnt++;
    for (int r = 0; r < 4; r++) begin
      if (bus.rsp_valid[r]) rsp_q.push_back('{r, bus.rsp_error, bus.rsp_digest});
    end
    @(posedge CLOCK_50);
    #1;
    for (int r = 0; r < 4; r++) begin
      if (taken[r]) bus.req_valid[r] = 1'b0;
    end
  endtask

  task automatic post(input int r, input logic f, input logic l, input logic [511:0] blk);
    bus.req_first[r]           = f;
    bus.req_last[r]            = l;
    bus.req_block[r*512 +: 512] = blk;
    bus.req_valid[r]           = 1'b1;
    $display("post  r=%0d first=%0d last=%0d blk=%0h", r, f, l, blk[31:0]);
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 400 && rsp_q.size() < n; i++) tick();
    check(tag, 256'(rsp_q.size()), 256'(n));
    for (int i = 0; i < rsp_q.size(); i++)
      $display("rsp   r=%0d err=%0d dig=%0h", rsp_q[i].r, rsp_q[i].err, rsp_q[i].dig);
  endtask

  task automatic clear_logs();
    grant_q.delete();
    grant_cyc_q.delete();
    init_cyc_q.delete();
    rsp_q.delete();
    next_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int gq(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -1;
  endfunction

  function automatic int rq_r(input int i);
    return (i < rsp_q.size()) ? rsp_q[i].r : -1;
  endfunction

  function automatic int rq_e(input int i);
    return (i < rsp_q.size()) ? int'(rsp_q[i].err) : -1;
  endfunction

  function automatic logic [255:0] rq_d(input int i);
    return (i < rsp_q.size()) ? rsp_q[i].dig : '1;
  endfunction

  // Checks one sequence of grants and responses against expected tables
  task automatic check_seq(input string tag, input int n, input int gexp[5],
                           input logic [511:0] bexp[5], input logic iexp[5]);
    check({tag, "_ngrant"}, 256'(grant_q.size()), 256'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_grant%0d", tag, i), 256'(gq(i)), 256'(gexp[i]));
      check($sformatf("%s_rspid%0d", tag, i), 256'(rq_r(i)), 256'(gexp[i]));
      check($sformatf("%s_err%0d", tag, i), 256'(rq_e(i)), 256'(0));
      check($sformatf("%s_dig%0d", tag, i), rq_d(i), model_digest(bexp[i], iexp[i]));
    end
  endtask

  initial begin
    int gexp[5];
    logic [511:0] bexp[5];
    logic iexp[5];
    logic [255:0] prev_dig;

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_first = '0;
    bus.req_last  = '0;
    bus.req_block = '0;
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;

    // Reset state
    check("rst_req_ready",  256'(bus.req_ready), 256'(0));
    check("rst_rsp_valid",  256'(bus.rsp_valid), 256'(0));
    check("rst_rsp_error",  256'(bus.rsp_error), 256'(0));
    check("rst_rsp_digest", bus.rsp_digest, 256'(0));
    check("rst_core_init",  256'(core_init), 256'(0));
    check("rst_core_next",  256'(core_next), 256'(0));
    check("rst_core_block", core_block[255:0] | core_block[511:256], 256'(0));
    check("rst_core_mode",  256'(core_mode), 256'(1));
    check("rst_busy",       256'(busy), 256'(0));

    // Single "abc" block
    clear_logs();
    post(0, 1'b1, 1'b1, ABC_BLK);
    wait_rsp("abc_nrsp", 1);
    check("abc_ngrant", 256'(grant_q.size()), 256'(1));
    check("abc_grant",  256'(gq(0)), 256'(0));
    check("abc_init_at_a1", 256'((init_cyc_q.size() > 0 && grant_cyc_q.size() > 0) ?
          init_cyc_q[0] - grant_cyc_q[0] : -1), 256'(1));
    check("abc_next_cnt", 256'(next_cnt), 256'(0));
    check("abc_rspid",  256'(rq_r(0)), 256'(0));
    check("abc_err",    256'(rq_e(0)), 256'(0));
    check("abc_digest", rq_d(0), ABC_DIG);

    // Fairness from reset: 1,2,3 then wrap to 0 ahead of 1
    do_reset();
    clear_logs();
    post(1, 1'b1, 1'b1, mk_blk(11));
    post(2, 1'b1, 1'b1, mk_blk(12));
    post(3, 1'b1, 1'b1, mk_blk(13));
    wait_rsp("fair_nrsp3", 3);
    post(1, 1'b1, 1'b1, mk_blk(21));
    post(0, 1'b1, 1'b1, mk_blk(20));
    wait_rsp("fair_nrsp5", 5);
    gexp = '{1, 2, 3, 0, 1};
    bexp = '{mk_blk(11), mk_blk(12), mk_blk(13), mk_blk(20), mk_blk(21)};
    iexp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    check_seq("fair", 5, gexp, bexp, iexp);

    // Lock: 2 opens a message, 0 must wait for 2's continuation
    clear_logs();
    post(0, 1'b1, 1'b1, mk_blk(30));
    post(2, 1'b1, 1'b0, mk_blk(32));
    wait_rsp("lock_nrsp1", 1);
    repeat (6) tick();
    post(2, 1'b0, 1'b1, mk_blk(33));
    wait_rsp("lock_nrsp3", 3);
    gexp = '{2, 2, 0, 0, 0};
    bexp = '{mk_blk(32), mk_blk(33), mk_blk(30), '0, '0};
    iexp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    check_seq("lock", 3, gexp, bexp, iexp);
    check("lock_next_cnt", 256'(next_cnt), 256'(1));
    check("lock_init_cnt", 256'(init_cyc_q.size()), 256'(2));
    prev_dig = model_digest(mk_blk(30), 1'b1);

    // Rejected continuation from an unlocked requester
    clear_logs();
    post(3, 1'b0, 1'b1, mk_blk(43));
    wait_rsp("err_nrsp", 1);
    check("err_rspid",  256'(rq_r(0)), 256'(3));
    check("err_flag",   256'(rq_e(0)), 256'(1));
    check("err_digest_kept", rq_d(0), prev_dig);
    check("err_no_init", 256'(init_cyc_q.size()), 256'(0));
    check("err_no_next", 256'(next_cnt), 256'(0));
    post(1, 1'b1, 1'b1, mk_blk(51));
    post(0, 1'b1, 1'b1, mk_blk(50));
    wait_rsp("err_nrsp3", 3);
    check("err_ptr_grant1", 256'(gq(1)), 256'(0));
    check("err_ptr_grant2", 256'(gq(2)), 256'(1));

    // Reset while waiting for the digest
    clear_logs();
    post(2, 1'b1, 1'b0, mk_blk(62));
    for (int i = 0; i < 300 && !(busy && !core_ready); i++) tick();
    check("mid_reach_wait", 256'(busy && !core_ready), 256'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy_low",  256'(busy), 256'(0));
    check("mid_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    check("mid_core_ready_busy", 256'(core_ready), 256'(0));
    post(0, 1'b1, 1'b1, mk_blk(70));
    wait_rsp("mid_nrsp", 1);
    repeat (20) tick();
    check("mid_nrsp_final", 256'(rsp_q.size()), 256'(1));
    check("mid_grants", 256'(grant_q.size()), 256'(2));
    check("mid_grant0", 256'(gq(1)), 256'(0));
    check("mid_rspid", 256'(rq_r(0)), 256'(0));
    check("mid_err",   256'(rq_e(0)), 256'(0));
    check("mid_digest", rq_d(0), model_digest(mk_blk(70), 1'b1));

    // Grants only while core_ready and never more than one at a time
    check("handshake_viol", 256'(hs_viol), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
